// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO.
// Supports 5..9 data bits, none/even/odd parity, 1 or 2 stop bits, and back-to-back frames.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tx_enable,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int BW       = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;
    localparam int NW       = $clog2(DATA_BITS);

    localparam logic [BW-1:0] BAUD_END = BW'(BAUD_DIV - 1);
    localparam logic [NW-1:0] BIT_END  = NW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_overflow;

    state_t               r_state;
    state_t               w_state_next;
    logic [BW-1:0]        r_baud;
    logic [NW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_en;
    logic                 r_par_bit;
    logic                 r_two_stop;
    logic                 r_stop2;
    logic                 r_tx_done;

    logic                 w_push;
    logic                 w_load;
    logic                 w_done;
    logic                 w_baud_end;
    logic [DATA_BITS-1:0] w_head;

    assign full       = (r_count == CW'(FIFO_DEPTH));
    assign empty      = (r_count == '0);
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign tx_done    = r_tx_done;

    assign w_push     = wr_en && !full;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_baud_end = (r_baud == BAUD_END);

    // Storage has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= wr_en && full;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_load})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (tx_enable && !empty) begin
                    w_load       = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_end && r_bit == BIT_END) begin
                    w_state_next = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_baud_end) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_baud_end && (!r_two_stop || r_stop2)) begin
                    w_done = 1'b1;
                    // Chain straight into the next start bit when data waits.
                    if (tx_enable && !empty) begin
                        w_load       = 1'b1;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        tx      = 1'b1;
        tx_busy = (r_state != S_IDLE) || w_load;
        unique case (r_state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = r_shift[0];
            S_PARITY: tx = r_par_bit;
            default:  tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_two_stop <= 1'b0;
            r_stop2    <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= w_done;
            if (w_load) begin
                r_shift    <= w_head;
                r_par_en   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                r_par_bit  <= (parity_mode == 2'b10) ? ~^w_head : ^w_head;
                r_two_stop <= two_stop;
                r_baud     <= '0;
                r_bit      <= '0;
                r_stop2    <= 1'b0;
            end else if (r_state != S_IDLE) begin
                if (w_baud_end) begin
                    r_baud <= '0;
                    if (r_state == S_DATA) begin
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + NW'(1);
                    end
                    if (r_state == S_STOP) begin
                        r_stop2 <= 1'b1;
                    end
                end else begin
                    r_baud <= r_baud + BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: BAUD_DIV=10, 8 data bits, 4-entry FIFO.
// Frames are given as hand-built bit vectors, bit 0 transmitted first.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_enable;
    logic [1:0] parity_mode;
    logic       two_stop;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_fifo #(
        .CLK_FREQ   (100),
        .BAUD_RATE  (10),
        .DATA_BITS  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_enable   (tx_enable),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .empty       (empty),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Entered on the negedge showing the first start-bit cycle; returns
    // on the negedge right after the last stop cycle.
    task automatic run_frame(input logic [11:0] bits, input int nb,
                             input int drop_at);
        for (int i = 0; i < nb; i++) begin
            for (int j = 0; j < 10; j++) begin
                check("tx_bit", 32'(tx), 32'(bits[i]));
                check("busy_in_frame", 32'(tx_busy), 32'd1);
                if (i != 0 || j != 0) begin
                    check("done_in_frame", 32'(tx_done), 32'd0);
                end
                if (i * 10 + j == drop_at) begin
                    tx_enable = 1'b0;
                end
                @(negedge clk);
            end
        end
        check("done_pulse", 32'(tx_done), 32'd1);
    endtask

    initial begin
        reset       = 1'b1;
        tx_enable   = 1'b0;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        wr_en       = 1'b0;
        wr_data     = '0;
        repeat (2) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        reset     = 1'b0;
        tx_enable = 1'b1;

        // 0xA5, no parity, one stop: 0,1,0,1,0,0,1,0,1,1
        push(8'hA5);
        check("a5_count", 32'(fifo_count), 32'd1);
        check("a5_load_busy", 32'(tx_busy), 32'd1);
        check("a5_latency_tx", 32'(tx), 32'd1);
        @(negedge clk);
        run_frame(12'b00_1_10100101_0, 10, -1);
        check("a5_idle_busy", 32'(tx_busy), 32'd0);
        check("a5_idle_empty", 32'(empty), 32'd1);

        // 0x07 even parity -> parity bit 1, 110 cycles
        parity_mode = 2'b01;
        push(8'h07);
        @(negedge clk);
        run_frame(12'b0_1_1_00000111_0, 11, -1);
        check("even_idle_tx", 32'(tx), 32'd1);

        // 0x07 odd parity, two stops; config changed after load is ignored
        parity_mode = 2'b10;
        two_stop    = 1'b1;
        push(8'h07);
        @(negedge clk);
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        run_frame(12'b11_0_00000111_0, 12, -1);
        check("odd2_idle_busy", 32'(tx_busy), 32'd0);

        // three queued frames sent back-to-back
        tx_enable = 1'b0;
        push(8'h11);
        push(8'h22);
        push(8'h3C);
        check("b2b_count3", 32'(fifo_count), 32'd3);
        tx_enable = 1'b1;
        @(negedge clk);
        check("b2b_count2", 32'(fifo_count), 32'd2);
        run_frame(12'b00_1_00010001_0, 10, -1);
        run_frame(12'b00_1_00100010_0, 10, -1);
        run_frame(12'b00_1_00111100_0, 10, -1);
        check("b2b_idle_busy", 32'(tx_busy), 32'd0);
        check("b2b_empty", 32'(empty), 32'd1);

        // overflow on a 4-entry FIFO
        tx_enable = 1'b0;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_count4", 32'(fifo_count), 32'd4);
        check("ovf_none_yet", 32'(overflow), 32'd0);
        push(8'hEE);
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_count_kept", 32'(fifo_count), 32'd4);
        check("ovf_full_kept", 32'(full), 32'd1);
        @(negedge clk);
        check("ovf_one_cycle", 32'(overflow), 32'd0);

        // disable mid-frame with two entries still queued
        tx_enable = 1'b1;
        @(negedge clk);
        run_frame(12'b00_1_00000001_0, 10, -1);
        run_frame(12'b00_1_00000010_0, 10, 50);
        check("dis_busy", 32'(tx_busy), 32'd0);
        check("dis_count", 32'(fifo_count), 32'd2);
        check("dis_tx", 32'(tx), 32'd1);
        @(negedge clk);
        check("dis_stay_idle", 32'(tx_busy), 32'd0);
        tx_enable = 1'b1;
        @(negedge clk);
        run_frame(12'b00_1_00000011_0, 10, -1);

        // reset at cycle 35 of the 0x04 frame, with one more byte queued
        push(8'h55);
        check("rst_mid_count", 32'(fifo_count), 32'd1);
        repeat (34) @(negedge clk);
        check("rst_mid_tx", 32'(tx), 32'd1);
        check("rst_mid_busy", 32'(tx_busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(tx_busy), 32'd0);
        check("abort_empty", 32'(empty), 32'd1);
        check("abort_count", 32'(fifo_count), 32'd0);
        check("abort_done", 32'(tx_done), 32'd0);
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            check("after_abort_done", 32'(tx_done), 32'd0);
            check("after_abort_tx", 32'(tx), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised next-generation UART transmitter with an integrated transmit FIFO.
- Adds configurable data width, selectable parity (none/even/odd) and 1 or 2 stop bits.
- Sends queued frames back-to-back with no idle gap between them.
- Sits behind the APB peripheral register block; software pushes bytes into the FIFO and the serialiser drains it onto the line.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz
- BAUD_RATE, 9600, line rate in baud; BAUD_DIV = CLK_FREQ / BAUD_RATE (integer division, must be >= 2)
- DATA_BITS, 8, data bits per frame, legal range 5..9
- FIFO_DEPTH, 16, FIFO entries, power of two, >= 2

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- tx_enable  input  1  allows new frames to start
- parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none
- two_stop  input  1  0 = one stop bit, 1 = two stop bits
- wr_en  input  1  push wr_data into the FIFO
- wr_data  input  DATA_BITS  frame payload
- full  output  1  FIFO holds FIFO_DEPTH entries
- empty  output  1  FIFO holds 0 entries
- fifo_count  output  clog2(FIFO_DEPTH)+1  number of occupied entries
- overflow  output  1  one-cycle pulse when a write is dropped
- tx  output  1  serial line, idle high
- tx_busy  output  1  a frame is in progress
- tx_done  output  1  one-cycle pulse at the end of each frame

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: tx=1, tx_busy=0, tx_done=0, overflow=0, full=0, empty=1, fifo_count=0. FIFO pointers and baud counter are cleared.
- Reset mid-frame aborts the frame: tx=1 on the next edge and queued data is discarded.
- FIFO write:
  - Accepted when wr_en=1 and registered full=0.
  - When wr_en=1 and full=1, the data is dropped and overflow pulses for one cycle. This holds even if a pop occurs in the same cycle.
- FIFO pop: occurs on the cycle a frame is loaded. A simultaneous push and pop leaves fifo_count unchanged.
- full, empty and fifo_count are registered and reflect the state after the current edge.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when tx_enable=1 and empty=0. The head entry is popped into the shift register in that cycle.
  - parity_mode and two_stop are latched at the same point; a config change mid-frame does not affect the frame in flight.
  - tx drives 0 from the cycle after the load.
- Bit timing: every bit, including each stop bit, lasts exactly BAUD_DIV clock cycles.
  - A baud counter counts 0..BAUD_DIV-1; the bit advances at terminal count.
- DATA: DATA_BITS bits, LSB first.
- PARITY: entered only if the latched mode is 01 or 10.
  - Even: parity bit = XOR of data bits.
  - Odd: parity bit = inverted XOR of data bits.
  - Otherwise DATA -> STOP directly.
- STOP: tx=1 for 1 or 2 bit periods. At the end of the last stop bit, tx_done pulses for one cycle.
  - If tx_enable=1 and empty=0 at that cycle, the next entry is popped and the state goes directly to START. The next start bit begins on the following cycle, so there is no idle gap.
  - Otherwise the state goes to IDLE.
- Frame length: BAUD_DIV x (1 + DATA_BITS + P + S) cycles, where P is 0 or 1 and S is 1 or 2.
- tx_busy: 1 from the load cycle through the last cycle of the final stop bit.
  - Stays 1 continuously across back-to-back frames.
  - Drops to 0 in IDLE.
- tx_enable deasserted mid-frame: the current frame completes normally; no new frame starts; the FIFO retains its contents.
- Writes to an empty FIFO while IDLE and enabled: the frame loads the cycle after the write (empty is registered). Start bit latency from wr_en is 2 cycles.
- All counters wrap modulo their width. FIFO pointers wrap at FIFO_DEPTH.

Test Plan:
- CLK_FREQ=100, BAUD_RATE=10 (BAUD_DIV=10), DATA_BITS=8, parity none, one stop; write 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles; tx_done pulses once 100 cycles after the start bit begins.
- Same setup, parity even, write 0x07 -> parity bit 1 (odd mode: 0); frame lasts 110 cycles; with two_stop=1 it lasts 120 cycles with 20 cycles of high stop.
- Write 3 bytes in consecutive cycles, then enable -> three frames back-to-back with no idle cycle; tx_busy stays 1 throughout; three tx_done pulses 100 cycles apart.
- FIFO_DEPTH=4, tx_enable=0, write 5 bytes -> full=1 after the 4th write; the 5th write is dropped with a one-cycle overflow pulse; fifo_count=4.
- Assert reset at cycle 35 of a frame -> tx=1 on the next edge; empty=1, fifo_count=0, tx_busy=0; no tx_done pulse.
- Deassert tx_enable mid-frame with 2 entries queued -> the frame finishes; the state returns to IDLE with fifo_count=2; re-enabling starts the next frame 1 cycle later.
